mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_dma_pkg.sv | 23 ++
 rtl/dma_addr_gen.sv | 38 +++
 rtl/mem_copy_dma.sv | 174 +++++++++++++++++
 tb/tb_mem_copy_dma.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory copy/fill DMA.
//   ADDR_W_DEFAULT / DATA_W_DEFAULT / DEPTH_DEFAULT : geometry of the attached 16x8 memory
//   state_e : controller states (IDLE, READ, WRITE, DONE)
//   mode_e  : transfer kind latched at start (copy or fill)
package mem_dma_pkg;

    localparam int ADDR_W_DEFAULT = 4;
    localparam int DATA_W_DEFAULT = 8;
    localparam int DEPTH_DEFAULT  = 2 ** ADDR_W_DEFAULT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable wrapping up/down address pointer.
//   clk, reset    : clock, asynchronous active-high reset (pointer -> 0, direction -> up)
//   load_i        : load load_addr_i and latch load_down_i as the stepping direction
//   load_addr_i   : start address
//   load_down_i   : 1 = step downwards, 0 = step upwards
//   step_i        : advance the pointer one entry in the latched direction
//   ptr_o         : current pointer; arithmetic wraps modulo 2**ADDR_W
module dma_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              load_down_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] ptr_q;
    logic              down_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            down_q <= 1'b0;
        end else if (load_i) begin
            ptr_q  <= load_addr_i;
            down_q <= load_down_i;
        end else if (step_i) begin
            // Natural ADDR_W-bit overflow gives the modulo-DEPTH wrap.
            ptr_q <= down_q ? ptr_q - 1'b1 : ptr_q + 1'b1;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/mem_copy_dma.sv
// Memory-to-memory copy / constant-fill DMA for a single-port-read,
// single-port-write memory with combinational read data.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : request pulse, only honoured in IDLE
//   mode              : 0 = copy, 1 = fill (latched at start)
//   src_addr/dst_addr : first source / destination address
//   length            : byte count, 0 legal, saturates to DEPTH
//   fill_value        : byte written in fill mode
//   busy / done       : transfer in progress / one-cycle completion pulse
//   mem_read_addr     : read port address, mem_read_data returns its contents
//   mem_write_*       : write port, commits on the next rising clk
// Copy runs READ/WRITE pairs (2 cycles per byte); fill stays in WRITE
// (1 cycle per byte). Overlapping copies pick the direction that keeps
// source bytes intact until read, i.e. memmove semantics.
module mem_copy_dma
    import mem_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

    state_e            state_q;
    mode_e             mode_q;
    logic [ADDR_W:0]   rem_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              we_q;

    // Start-time decode: saturated length, direction and first pointers.
    mode_e             mode_d;
    logic [ADDR_W:0]   len_d;
    logic [ADDR_W-1:0] len_m1_d;
    logic [ADDR_W-1:0] dist_d;
    logic              down_d;
    logic [ADDR_W-1:0] src_start_d;
    logic [ADDR_W-1:0] dst_start_d;
    logic              accept_d;
    logic              step_d;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;

    always_comb begin
        mode_d   = mode_e'(mode);
        len_d    = (length > LEN_MAX) ? LEN_MAX : length;
        len_m1_d = len_d[ADDR_W-1:0] - 1'b1;
        dist_d   = dst_addr - src_addr;
        // Destination starts inside the source window: walk backwards so
        // no source byte is overwritten before it has been read.
        down_d   = (mode_d == MODE_COPY) && (dist_d != '0) && ({1'b0, dist_d} < len_d);
        src_start_d = down_d ? src_addr + len_m1_d : src_addr;
        dst_start_d = down_d ? dst_addr + len_m1_d : dst_addr;
        accept_d = (state_q == IDLE) && start;
        step_d   = (state_q == WRITE);
    end

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept_d),
        .load_addr_i(src_start_d),
        .load_down_i(down_d),
        .step_i     (step_d),
        .ptr_o      (src_ptr)
    );

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept_d),
        .load_addr_i(dst_start_d),
        .load_down_i(down_d),
        .step_i     (step_d),
        .ptr_o      (dst_ptr)
    );

    // Controller with registered busy/done/write-enable: each flag is set on
    // the edge that enters the state in which it must be visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= MODE_COPY;
            rem_q     <= '0;
            data_q    <= '0;
            fill_q    <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode_d;
                        rem_q  <= len_d;
                        fill_q <= fill_value;
                        busy_q <= 1'b1;
                        if (len_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (mode_d == MODE_FILL) begin
                            state_q <= WRITE;
                            we_q    <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    data_q    <= mem_read_data;
                    rd_addr_q <= src_ptr;
                    state_q   <= WRITE;
                    we_q      <= 1'b1;
                end
                WRITE: begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        we_q    <= 1'b0;
                    end else if (mode_q == MODE_FILL) begin
                        state_q <= WRITE;
                        we_q    <= 1'b1;
                    end else begin
                        state_q <= READ;
                        we_q    <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    // Read address follows the source pointer only while reading and
    // otherwise holds the address of the last read.
    assign mem_read_addr    = (state_q == READ) ? src_ptr : rd_addr_q;
    assign mem_write_enable = we_q;
    assign mem_write_addr   = dst_ptr;
    assign mem_write_data   = (mode_q == MODE_FILL) ? fill_q : data_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mode;
  logic [3:0] src_addr;
  logic [3:0] dst_addr;
  logic [4:0] length;
  logic [7:0] fill_value;
  logic       busy;
  logic       done;
  logic [3:0] mem_read_addr;
  logic [7:0] mem_read_data;
  logic       mem_write_enable;
  logic [3:0] mem_write_addr;
  logic [7:0] mem_write_data;

  int checks;
  int failures;

  // memory model, write log and bench-side preload port
  logic [7:0] mem [16];
  logic [7:0] exp_mem [16];
  logic [3:0] wr_log [$];
  logic       tb_we;
  logic [3:0] tb_wa;
  logic [7:0] tb_wd;

  mem_copy_dma dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .length          (length),
    .fill_value      (fill_value),
    .busy            (busy),
    .done            (done),
    .mem_read_addr   (mem_read_addr),
    .mem_read_data   (mem_read_data),
    .mem_write_enable(mem_write_enable),
    .mem_write_addr  (mem_write_addr),
    .mem_write_data  (mem_write_data)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_addr];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_write_addr] <= mem_write_data;
      wr_log.push_back(mem_write_addr);
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end
  end

  // driver tasks
  task automatic preload_ramp();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      tb_we = 1'b1; tb_wa = 4'(i); tb_wd = 8'(i + 16);
      exp_mem[i] = 8'(i + 16);
    end
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    exp_mem[a] = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Returns the cycle (counted from the accepting edge) on which done is seen, -1 on timeout.
  task automatic run_xfer(input logic m, input logic [3:0] s, input logic [3:0] d,
                          input logic [4:0] l, input logic [7:0] f, output int cyc);
    @(posedge clk); #1;
    mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_write_enable); end
    checks++; if (mem_read_addr !== 4'd0) begin failures++; $display("FAIL reset_raddr got=%0d exp=0", mem_read_addr); end
    checks++; if (mem_write_addr !== 4'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", mem_write_addr); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_copy_basic();
    int cyc;
    int base;
    preload_ramp();
    base = wr_log.size();
    run_xfer(1'b0, 4'd2, 4'd8, 5'd4, 8'h00, cyc);
    for (int i = 0; i < 4; i++) exp_mem[8 + i] = 8'(8'h12 + i);
    checks++; if (cyc !== 9) begin failures++; $display("FAIL copy_done_cycle got=%0d exp=9", cyc); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL copy_busy_at_done got=%b exp=1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL copy_idle_after got=%b%b exp=00", busy, done); end
    checks++; if (wr_log.size() - base !== 4) begin failures++; $display("FAIL copy_writes got=%0d exp=4", wr_log.size() - base); end
    checks++; if (wr_log[base] !== 4'd8) begin failures++; $display("FAIL copy_first_addr got=%0d exp=8", wr_log[base]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL copy_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_overlap();
    int cyc;
    int base;
    preload_ramp();
    for (int i = 0; i < 4; i++) poke(4'(i), 8'(8'hA0 + i));
    base = wr_log.size();
    run_xfer(1'b0, 4'd0, 4'd1, 5'd4, 8'h00, cyc);
    for (int i = 0; i < 4; i++) exp_mem[1 + i] = 8'(8'hA0 + i);
    checks++; if (cyc !== 9) begin failures++; $display("FAIL overlap_done_cycle got=%0d exp=9", cyc); end
    checks++; if (wr_log[base] !== 4'd4) begin failures++; $display("FAIL overlap_first_addr got=%0d exp=4", wr_log[base]); end
    checks++; if (wr_log[base + 3] !== 4'd1) begin failures++; $display("FAIL overlap_last_addr got=%0d exp=1", wr_log[base + 3]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL overlap_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_wrap();
    int cyc;
    int base;
    preload_ramp();
    base = wr_log.size();
    run_xfer(1'b1, 4'd0, 4'd14, 5'd4, 8'h5A, cyc);
    exp_mem[14] = 8'h5A; exp_mem[15] = 8'h5A; exp_mem[0] = 8'h5A; exp_mem[1] = 8'h5A;
    checks++; if (cyc !== 5) begin failures++; $display("FAIL fill_done_cycle got=%0d exp=5", cyc); end
    checks++; if (wr_log.size() - base !== 4) begin failures++; $display("FAIL fill_writes got=%0d exp=4", wr_log.size() - base); end
    checks++; if (wr_log[base + 2] !== 4'd0) begin failures++; $display("FAIL fill_wrap_addr got=%0d exp=0", wr_log[base + 2]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL fill_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len_zero();
    int cyc;
    int base;
    base = wr_log.size();
    run_xfer(1'b0, 4'd3, 4'd9, 5'd0, 8'h00, cyc);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL len0_done_cycle got=%0d exp=1", cyc); end
    @(posedge clk); #1;
    checks++; if (wr_log.size() - base !== 0) begin failures++; $display("FAIL len0_writes got=%0d exp=0", wr_log.size() - base); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_len_saturate();
    int cyc;
    int base;
    preload_ramp();
    base = wr_log.size();
    run_xfer(1'b1, 4'd0, 4'd3, 5'd20, 8'h33, cyc);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h33;
    checks++; if (cyc !== 17) begin failures++; $display("FAIL sat_done_cycle got=%0d exp=17", cyc); end
    checks++; if (wr_log.size() - base !== 16) begin failures++; $display("FAIL sat_writes got=%0d exp=16", wr_log.size() - base); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL sat_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int cyc;
    int base;
    preload_ramp();
    base = wr_log.size();
    @(posedge clk); #1;
    mode = 1'b0; src_addr = 4'd0; dst_addr = 4'd8; length = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    @(posedge clk); #1;
    cyc = 2;
    // second request while busy, with very different parameters
    mode = 1'b1; dst_addr = 4'd0; length = 5'd16; fill_value = 8'hEE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    exp_mem[8] = 8'h10; exp_mem[9] = 8'h11;
    checks++; if (cyc !== 5) begin failures++; $display("FAIL ignore_done_cycle got=%0d exp=5", cyc); end
    checks++; if (wr_log.size() - base !== 2) begin failures++; $display("FAIL ignore_writes got=%0d exp=2", wr_log.size() - base); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL ignore_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int base;
    int guard;
    preload_ramp();
    base = wr_log.size();
    @(posedge clk); #1;
    mode = 1'b0; src_addr = 4'd0; dst_addr = 4'd8; length = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (wr_log.size() - base < 3 && guard < 100) begin @(posedge clk); #1; guard++; end
    while (mem_write_enable !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    checks++; if (guard >= 100) begin failures++; $display("FAIL midreset_reach got=timeout exp=4th_write"); end
    reset = 1'b1;
    #1;
    checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL midreset_we got=%b exp=0", mem_write_enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (mem_read_addr !== 4'd0) begin failures++; $display("FAIL midreset_raddr got=%0d exp=0", mem_read_addr); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_mem[8] = 8'h10; exp_mem[9] = 8'h11; exp_mem[10] = 8'h12;
    checks++; if (wr_log.size() - base !== 3) begin failures++; $display("FAIL midreset_writes got=%0d exp=3", wr_log.size() - base); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL midreset_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
    // transfer after reset behaves normally
    run_xfer(1'b0, 4'd4, 4'd12, 5'd2, 8'h00, cyc);
    exp_mem[12] = 8'h14; exp_mem[13] = 8'h15;
    checks++; if (cyc !== 5) begin failures++; $display("FAIL postreset_done_cycle got=%0d exp=5", cyc); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL postreset_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    #2;
    test_reset();
    test_copy_basic();
    test_overlap();
    test_fill_wrap();
    test_len_zero();
    test_len_saturate();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
